ttl_74259_sync: RTL and testbench
=================================

Name: ttl_74259_sync

Overview:
- Clocked 8-bit addressable latch and 1-to-N demultiplexer; the write-side counterpart of the 8-input data selector.
- A single data bit D is steered into the output latch bit chosen by Select.
- Used to rebuild parallel words from selector-serialised streams and to drive decoded strobes.
- An optional auto-scan sequencer captures a full serial frame into Q without external addressing.

Parameters:
- WIDTH_OUT, 8, number of latch outputs.
- WIDTH_SELECT, $clog2(WIDTH_OUT), address width.
- DELAY_RISE, 0, rise delay applied to Q and scan outputs.
- DELAY_FALL, 0, fall delay applied to Q and scan outputs.

Ports:
- Clk  input  1  rising-edge clock.
- Clear  input  1  synchronous, active-high reset.
- Enable_bar  input  1  active-low write enable.
- Demux  input  1  0 = addressable-latch mode; 1 = demux mode.
- Select  input  WIDTH_SELECT  target bit address.
- D  input  1  data bit.
- Scan_start  input  1  begin auto-scan (feature only).
- Q  output  WIDTH_OUT  latch outputs.
- Scan_busy  output  1  scan in progress.
- Scan_done  output  1  one-cycle pulse at frame end.

Behaviour:
- One clock domain; reset is synchronous and active-high. All state changes happen on the rising edge of Clk. Outputs are registered and visible one edge after inputs are sampled, plus DELAY_RISE/DELAY_FALL.
- Reset (Clear=1 at an edge):
  - Q = 0, Scan_busy = 0, Scan_done = 0.
  - Scan counter = 0, state = IDLE.
  - Clear has priority over every other input.
- Mode table (Clear=0, no scan active):
  - Enable_bar=1, Demux=0: hold; Q unchanged.
  - Enable_bar=0, Demux=0: Q[Select] <= D; all other bits hold.
  - Enable_bar=0, Demux=1: Q <= 0, except Q[Select] <= D.
  - Enable_bar=1, Demux=1: Q <= 0 (mode clear, same effect as Clear on Q only).
- Select >= WIDTH_OUT (non-power-of-2 widths):
  - Latch mode: no bit written; Q holds.
  - Demux mode: Q <= 0.
- X/Z on Select while enabled: no write, Q holds.
- There is no combinational path from inputs to Q.

Optional Feature:
- Macro: TTL_74259_AUTO_SCAN_EN.
- With the macro, states are IDLE, SCAN and DONE:
  - IDLE: Scan_start=1 with Clear=0 -> SCAN. The counter is loaded with 0; no write on that edge. Scan_busy=1 from the next cycle.
  - SCAN, Enable_bar=0: Q[counter] <= D, counter += 1. Demux and Select are ignored; other bits hold.
  - SCAN, Enable_bar=1: stall; counter and Q hold; Scan_busy stays 1.
  - Write at counter = WIDTH_OUT-1 -> DONE. The counter wraps to 0.
  - DONE: Scan_done=1 for exactly one cycle, Scan_busy=0 -> IDLE. Normal modes resume in that same cycle.
  - Scan_start is ignored in SCAN and DONE.
  - Scan_start asserted on the DONE edge is honoured on the next edge, from IDLE.
  - Clear mid-scan: abort to IDLE, Q=0, no Scan_done pulse.
- Without the macro:
  - Scan_start is ignored.
  - Scan_busy and Scan_done are tied to 0.
  - Port list is unchanged.

Test Plan:
- Clear=1 for one edge after random Q -> Q=8'h00, Scan_busy=0, Scan_done=0.
- Latch mode, Enable_bar=0, Demux=0: Select=3 D=1, then Select=6 D=1, then Select=3 D=0 -> Q=8'h08, then 8'h48, then 8'h40.
- Demux mode from Q=8'hFF: Demux=1, Enable_bar=0, Select=5, D=1 -> Q=8'h20. Then Enable_bar=1, Demux=1 -> Q=8'h00. Then Enable_bar=1, Demux=0 -> Q holds 8'h00.
- Hold and priority: Q=8'hA5, Enable_bar=1, Demux=0, D toggling for 4 cycles -> Q stays 8'hA5. Clear=1 with Enable_bar=0, Select=0, D=1 -> Q=8'h00.
- Scan with macro: pulse Scan_start, then feed D=1,0,1,0,0,1,0,1 at Enable_bar=0 -> Q=8'hA5 after 8 write edges. Scan_busy=1 across the frame, then Scan_done=1 for one cycle. One Enable_bar=1 cycle mid-frame -> completion slips by exactly one cycle.
- Scan abort and disabled build:
  - With macro: Clear asserted after 3 scan writes -> Q=0, IDLE, no Scan_done.
  - Without macro: Scan_start pulses -> Scan_busy and Scan_done stay 0; Q follows the mode table.

Source files
------------

// File: rtl/ttl_74259_sync.sv
// rtl/ttl_74259_sync.sv - clocked addressable latch / 1-to-N demux, optional auto-scan sequencer under TTL_74259_AUTO_SCAN_EN
module ttl_74259_sync #(
    parameter int WIDTH_OUT    = 8,
    parameter int WIDTH_SELECT = $clog2(WIDTH_OUT),
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic                    Clk,
    input  logic                    Clear,
    input  logic                    Enable_bar,
    input  logic                    Demux,
    input  logic [WIDTH_SELECT-1:0] Select,
    input  logic                    D,
    input  logic                    Scan_start,
    output logic [WIDTH_OUT-1:0]    Q,
    output logic                    Scan_busy,
    output logic                    Scan_done
);

    // Q plus the two scan flags travel together through the output delay stage.
    localparam int OUT_BITS  = WIDTH_OUT + 2;
    localparam int DELAY_MAX = (DELAY_RISE > DELAY_FALL) ? DELAY_RISE : DELAY_FALL;
    localparam logic [WIDTH_SELECT:0] SEL_LIMIT = (WIDTH_SELECT + 1)'(WIDTH_OUT);

    logic                 sel_ok;
    logic                 sel_unknown;
    logic [WIDTH_OUT-1:0] sel_mask;
    logic [WIDTH_OUT-1:0] q_reg;
    logic [WIDTH_OUT-1:0] q_mode;
    logic                 busy_now;
    logic                 done_now;
    logic [OUT_BITS-1:0]  now_bits;
    logic [OUT_BITS-1:0]  out_bits;

    // Decode Select into a one-hot write mask; out-of-range addresses select nothing.
    always_comb begin
        sel_unknown = $isunknown(Select);
        sel_ok      = ({1'b0, Select} < SEL_LIMIT) && !sel_unknown;
        sel_mask    = sel_ok ? (WIDTH_OUT'(1) << Select) : '0;
    end

    // Next Q under the plain mode table (no scan in progress).
    always_comb begin
        q_mode = q_reg;
        if (!Enable_bar && sel_unknown) begin
            // An unresolved address must not corrupt the latch in either mode.
            q_mode = q_reg;
        end else if (Demux) begin
            // Demux mode: everything cleared, only the addressed bit may carry D.
            q_mode = (!Enable_bar && D) ? sel_mask : '0;
        end else if (!Enable_bar) begin
            q_mode = D ? (q_reg | sel_mask) : (q_reg & ~sel_mask);
        end
    end

`ifdef TTL_74259_AUTO_SCAN_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH_SELECT-1:0] LAST_COUNT = WIDTH_SELECT'(WIDTH_OUT - 1);

    state_t                  state;
    state_t                  state_next;
    logic [WIDTH_SELECT-1:0] count;
    logic [WIDTH_SELECT-1:0] count_next;
    logic [WIDTH_OUT-1:0]    count_mask;
    logic [WIDTH_OUT-1:0]    q_next;

    // Sequencer state, scan counter and latch register; Clear aborts any frame.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            state <= ST_IDLE;
            count <= '0;
            q_reg <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            q_reg <= q_next;
        end
    end

    // Sequencer next state: the counter replaces Select during a frame, Enable_bar stalls it.
    always_comb begin
        state_next = state;
        count_next = count;
        q_next     = q_mode;
        count_mask = WIDTH_OUT'(1) << count;
        case (state)
            ST_IDLE: begin
                if (Scan_start) begin
                    // The start edge only arms the frame; nothing is written on it.
                    state_next = ST_SCAN;
                    count_next = '0;
                    q_next     = q_reg;
                end
            end
            ST_SCAN: begin
                q_next = q_reg;
                if (!Enable_bar) begin
                    q_next = D ? (q_reg | count_mask) : (q_reg & ~count_mask);
                    if (count == LAST_COUNT) begin
                        count_next = '0;
                        state_next = ST_DONE;
                    end else begin
                        count_next = count + WIDTH_SELECT'(1);
                    end
                end
            end
            ST_DONE: begin
                // Frame-end cycle: normal modes already apply, Scan_start is not looked at.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                q_next     = q_reg;
            end
        endcase
    end

    assign busy_now = (state == ST_SCAN);
    assign done_now = (state == ST_DONE);
`else
    logic unused_scan_start;

    // Latch register follows the mode table directly.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_mode;
        end
    end

    assign busy_now          = 1'b0;
    assign done_now          = 1'b0;
    assign unused_scan_start = Scan_start;
`endif

    assign now_bits = {busy_now, done_now, q_reg};

    // Output delay stage: rising edges appear DELAY_RISE cycles late, falling edges DELAY_FALL.
    generate
        if (DELAY_MAX == 0) begin : g_no_delay
            assign out_bits = now_bits;
        end else begin : g_delay
            logic [OUT_BITS-1:0] line [1:DELAY_MAX];
            logic [OUT_BITS-1:0] tap_rise;
            logic [OUT_BITS-1:0] tap_fall;

            // History line: line[k] holds the undelayed outputs from k cycles ago.
            always_ff @(posedge Clk) begin
                if (Clear) begin
                    for (int k = 1; k <= DELAY_MAX; k++) begin
                        line[k] <= '0;
                    end
                end else begin
                    line[1] <= now_bits;
                    for (int k = 2; k <= DELAY_MAX; k++) begin
                        line[k] <= line[k-1];
                    end
                end
            end

            if (DELAY_RISE == 0) begin : g_rise_now
                assign tap_rise = now_bits;
            end else begin : g_rise_line
                assign tap_rise = line[DELAY_RISE];
            end

            if (DELAY_FALL == 0) begin : g_fall_now
                assign tap_fall = now_bits;
            end else begin : g_fall_line
                assign tap_fall = line[DELAY_FALL];
            end

            // The longer tap governs the edge it belongs to: AND stretches rises, OR stretches falls.
            if (DELAY_RISE >= DELAY_FALL) begin : g_slow_rise
                assign out_bits = tap_rise & tap_fall;
            end else begin : g_slow_fall
                assign out_bits = tap_rise | tap_fall;
            end
        end
    endgenerate

    assign Q         = out_bits[WIDTH_OUT-1:0];
    assign Scan_done = out_bits[WIDTH_OUT];
    assign Scan_busy = out_bits[WIDTH_OUT+1];

endmodule

// File: tb/tb_ttl_74259_sync.sv
// tb/tb_ttl_74259_sync.sv - scoreboard bench for ttl_74259_sync with a frame-level reference model
module tb_ttl_74259_sync;

    localparam int W = 8;
`ifdef TTL_74259_AUTO_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clear;
    logic         en_b;
    logic         dmx;
    logic [2:0]   sel;
    logic         d;
    logic         start;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    ttl_74259_sync dut (
        .Clk        (clk),
        .Clear      (clear),
        .Enable_bar (en_b),
        .Demux      (dmx),
        .Select     (sel),
        .D          (d),
        .Scan_start (start),
        .Q          (q),
        .Scan_busy  (busy),
        .Scan_done  (done)
    );

    typedef struct {
        int           due;
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: Q as a word, frame position as an index (-1 = no frame), pending end-of-frame flag.
    bit [W-1:0] m_q     = '0;
    int         m_idx   = -1;
    bit         m_done  = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void apply_mode(bit eb, bit dm, int s, bit dd);
        bit [W-1:0] t;
        t = '0;
        if (dm) begin
            if (!eb && s < W) t[s] = dd;
            m_q = t;
        end else if (!eb && s < W) begin
            m_q[s] = dd;
        end
    endfunction

    function automatic void model_edge(bit c, bit eb, bit dm, int s, bit dd, bit st);
        if (c) begin
            m_q    = '0;
            m_idx  = -1;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            apply_mode(eb, dm, s, dd);
        end else if (m_idx >= 0) begin
            if (!eb) begin
                m_q[m_idx] = dd;
                m_idx++;
                if (m_idx == W) begin
                    m_idx  = -1;
                    m_done = 1'b1;
                end
            end
        end else if (SCAN_EN && st) begin
            m_idx = 0;
        end else begin
            apply_mode(eb, dm, s, dd);
        end
    endfunction

    task automatic step(input string tag, input bit c, input bit eb, input bit dm,
                        input int s, input bit dd, input bit st);
        exp_t e;
        clear = c;
        en_b  = eb;
        dmx   = dm;
        sel   = 3'(s);
        d     = dd;
        start = st;
        model_edge(c, eb, dm, s, dd, st);
        e.due  = cyc + 1;
        e.q    = m_q;
        e.busy = (m_idx >= 0);
        e.done = m_done;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation whose edge has already happened.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (q !== mon_e.q || busy !== mon_e.busy || done !== mon_e.done) begin
                errors++;
                $display("FAIL %s cyc=%0d: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                         mon_e.tag, cyc, q, busy, done, mon_e.q, mon_e.busy, mon_e.done);
            end
        end
    end

    initial begin
        bit [7:0] frame;
        clear = 1'b1; en_b = 1'b1; dmx = 1'b0; sel = '0; d = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;

        step("reset", 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), 1, 1);
        for (int i = 0; i < 6; i++)
            step("prefill", 0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 1), 0);
        step("reset_after_data", 1, 0, 0, 2, 1, 0);

        step("latch_s3_d1", 0, 0, 0, 3, 1, 0);
        step("latch_s6_d1", 0, 0, 0, 6, 1, 0);
        step("latch_s3_d0", 0, 0, 0, 3, 0, 0);

        for (int i = 0; i < W; i++) step("fill_ff", 0, 0, 0, i, 1, 0);
        step("demux_s5", 0, 0, 1, 5, 1, 0);
        step("demux_disabled", 0, 1, 1, 2, 1, 0);
        step("hold_after_clear", 0, 1, 0, 4, 1, 0);

        frame = 8'hA5;
        for (int i = 0; i < W; i++) step("load_a5", 0, 0, 0, i, frame[i], 0);
        for (int i = 0; i < 4; i++) step("hold_a5", 0, 1, 0, $urandom_range(0, 7), i[0], 0);
        step("clear_priority", 1, 0, 0, 0, 1, 0);

        step("scan_start", 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < W; i++) step("scan_a5", 0, 0, $urandom_range(0, 1), $urandom_range(0, 7), frame[i], i == 3);
        step("scan_done", 0, 1, 1, 0, 0, 1);
        step("after_done_start", 0, 1, 0, 0, 0, 0);

        step("scan_start_stall", 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < W + 1; i++) begin
            if (i == 4) step("scan_stall", 0, 1, 0, 0, 1, 0);
            else step("scan_stall_frame", 0, 0, 0, 0, frame[(i > 4) ? i - 1 : i], 0);
        end
        step("stall_done", 0, 1, 0, 0, 0, 0);

        step("abort_start", 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("abort_writes", 0, 0, 0, 0, 1, 0);
        step("abort_clear", 1, 0, 0, 0, 1, 0);
        step("abort_idle", 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            step("random", $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7) == 0);

        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
